raster_stream_tx: RTL and testbench

- Raster pixel transmitter. It drives the valid-qualified pixel stream consumed by the line-buffer/shift-tap blocks in the image pipeline.
- Pulls pixels from an upstream ready/valid source, normally a frame FIFO.
- Emits exactly H_ACTIVE valid pixels per line and V_ACTIVE lines per frame, with programmable horizontal/vertical blanking gaps and sof/eol markers.
- This guarantees that downstream line-length-counting buffers stay line-aligned.

---
 rtl/raster_stream_tx.sv | 136 +++++++++++++
 tb/tb_raster_stream_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_stream_tx.sv
// Raster pixel transmitter: fixed H_ACTIVE x V_ACTIVE frames with timed blanking and sof/eol markers.
// Optional built-in test pattern (m_data = x+y) when RASTER_STREAM_TPG_EN is defined.
module raster_stream_tx #(
  parameter int WIDTH    = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
`ifdef RASTER_STREAM_TPG_EN
  input  logic             tpg_on_i,
`endif
  input  logic             s_valid_i,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             s_ready_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_sof_o,
  output logic             m_eol_o,
  output logic             busy_o
);

  localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] HB_LOAD = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [BW-1:0] VB_LOAD = BW'((V_BLANK > 0) ? V_BLANK - 1 : 0);

  // IDLE: wait for start | ACTIVE: move pixels | HBLANK/VBLANK: timed idle gaps
  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t           state_q;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic [BW-1:0]    blank_q;
  logic             m_valid_q;
  logic [WIDTH-1:0] m_data_q;
  logic             m_sof_q;
  logic             m_eol_q;
  logic             adv_d;
  logic [WIDTH-1:0] pix_d;

`ifdef RASTER_STREAM_TPG_EN
  logic tpg_q;

  assign s_ready_o = (state_q == ACTIVE) && !tpg_q;
  assign adv_d     = (state_q == ACTIVE) && (tpg_q || s_valid_i);
  assign pix_d     = tpg_q ? WIDTH'(32'(x_q) + 32'(y_q)) : s_data_i;
`else
  assign s_ready_o = (state_q == ACTIVE);
  assign adv_d     = s_ready_o && s_valid_i;
  assign pix_d     = s_data_i;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      blank_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
`ifdef RASTER_STREAM_TPG_EN
      tpg_q     <= 1'b0;
`endif
    end else begin
      // Flags are forced low on non-valid cycles; data simply holds.
      m_valid_q <= adv_d;
      m_sof_q   <= adv_d && (x_q == '0) && (y_q == '0);
      m_eol_q   <= adv_d && (x_q == X_LAST);
      if (adv_d) m_data_q <= pix_d;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ACTIVE;
            x_q     <= '0;
            y_q     <= '0;
`ifdef RASTER_STREAM_TPG_EN
            tpg_q   <= tpg_on_i;
`endif
          end
        end
        ACTIVE: begin
          if (adv_d) begin
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q == Y_LAST) begin
                y_q <= '0;
                if (V_BLANK == 0) begin
                  state_q <= IDLE;
                end else begin
                  state_q <= VBLANK;
                  blank_q <= VB_LOAD;
                end
              end else begin
                y_q <= y_q + 1'b1;
                if (H_BLANK != 0) begin
                  state_q <= HBLANK;
                  blank_q <= HB_LOAD;
                end
              end
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        HBLANK: begin
          if (blank_q == '0) state_q <= ACTIVE;
          else               blank_q <= blank_q - 1'b1;
        end
        VBLANK: begin
          if (blank_q == '0) state_q <= IDLE;
          else               blank_q <= blank_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_sof_o   = m_sof_q;
  assign m_eol_o   = m_eol_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_raster_stream_tx.sv
// Self-checking bench for raster_stream_tx: frame-level reference model with randomized stalls/data.
module tb_raster_stream_tx;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int HB = 2;
  localparam int VB = 3;
  localparam int N  = H * V;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_sof;
  logic         m_eol;
  logic         busy;
`ifdef RASTER_STREAM_TPG_EN
  logic         tpg_on = 1'b0;
`endif

  raster_stream_tx #(.WIDTH(W), .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .clock_i  (clk),
    .reset_i  (rst),
    .start_i  (start),
`ifdef RASTER_STREAM_TPG_EN
    .tpg_on_i (tpg_on),
`endif
    .s_valid_i(s_valid),
    .s_data_i (s_data),
    .s_ready_o(s_ready),
    .m_valid_o(m_valid),
    .m_data_o (m_data),
    .m_sof_o  (m_sof),
    .m_eol_o  (m_eol),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observed output beats of the last frame and the pixels the source handed over.
  logic [W-1:0] obs_data[$];
  bit           obs_sof[$];
  bit           obs_eol[$];
  int           obs_cyc[$];
  logic [W-1:0] exp_data[$];
  int           busy_drop;
  int           busy_first;
  int           flag_leak;
  int           ready_seen;

  // Reference rules: pixel k of a frame is line k/H, column k%H.
  function automatic bit ref_eol(input int k);
    return (k % H) == (H - 1);
  endfunction
  function automatic int ref_min_gap(input int k);
    return ((k % H) == 0) ? HB + 1 : 1;
  endfunction

  // Pulses start on the current (negedge) cycle and plays an upstream source until busy drops.
  task automatic drive_frame(input int stall_pct, input int stall_at, input int stall_len,
                             input bit poke, input int abort_at, input bit rand_data, input bit tpg);
    int n;
    int used;
    logic [W-1:0] val;
    n = 0; used = 0; val = 1;
    obs_data.delete(); obs_sof.delete(); obs_eol.delete(); obs_cyc.delete(); exp_data.delete();
    busy_drop = -1; busy_first = 0; flag_leak = 0; ready_seen = 0;
`ifdef RASTER_STREAM_TPG_EN
    tpg_on = tpg;
`endif
    start = 1'b1;
    s_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 0) busy_first = int'(busy);
      if (m_valid) begin
        obs_data.push_back(m_data); obs_sof.push_back(m_sof);
        obs_eol.push_back(m_eol);   obs_cyc.push_back(cyc);
      end else if (m_sof || m_eol) begin
        flag_leak++;
      end
      if (s_ready) ready_seen++;
      if (!busy) begin
        busy_drop = cyc;
        break;
      end
      if (n == abort_at) begin
        s_valid = 1'b0;
        return;
      end
      start = poke && !s_ready;
      s_valid = ($urandom_range(0, 99) >= stall_pct);
      if (n == stall_at && used < stall_len) begin
        s_valid = 1'b0;
        used++;
      end
      s_data = rand_data ? W'($urandom) : val;
      if (s_valid && s_ready) begin
        exp_data.push_back(s_data);
        n++;
        val++;
      end
    end
    s_valid = 1'b0;
    start = 1'b0;
    if (busy_drop < 0) begin
      checks++; errors++;
      $display("FAIL frame_timeout: busy never dropped within 400 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_valid, m_sof, m_eol, busy, s_ready, m_data} !== '0) begin
      errors++;
      $display("FAIL reset_init: got v=%b sof=%b eol=%b busy=%b rdy=%b data=%0d, need all 0",
               m_valid, m_sof, m_eol, busy, s_ready, m_data);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    drive_frame(0, -1, 0, 1'b0, -1, 1'b0, 1'b0);
    checks++;
    if (obs_data.size() != N) begin errors++; $display("FAIL basic_count: got %0d beats, need %0d", obs_data.size(), N); end
    checks++;
    if (exp_data.size() != N) begin errors++; $display("FAIL basic_xfers: got %0d transfers, need %0d", exp_data.size(), N); end
    for (int k = 0; k < obs_data.size() && k < N; k++) begin
      checks++;
      if (obs_data[k] !== W'(k + 1)) begin errors++; $display("FAIL basic_data k=%0d: got %0d need %0d", k, obs_data[k], k + 1); end
      checks++;
      if (obs_sof[k] !== (k == 0) || obs_eol[k] !== ref_eol(k)) begin
        errors++; $display("FAIL basic_flags k=%0d: got sof=%b eol=%b need sof=%b eol=%b", k, obs_sof[k], obs_eol[k], k == 0, ref_eol(k));
      end
      if (k > 0) begin
        checks++;
        if (obs_cyc[k] - obs_cyc[k-1] != ref_min_gap(k)) begin
          errors++; $display("FAIL basic_gap k=%0d: got %0d need %0d", k, obs_cyc[k] - obs_cyc[k-1], ref_min_gap(k));
        end
      end
    end
    if (obs_cyc.size() > 0) begin
      checks++;
      if (busy_drop - obs_cyc[obs_cyc.size()-1] != VB) begin
        errors++; $display("FAIL basic_busy_drop: got %0d cycles after last beat, need %0d", busy_drop - obs_cyc[obs_cyc.size()-1], VB);
      end
    end
    checks++;
    if (busy_first != 1 || flag_leak != 0) begin
      errors++; $display("FAIL basic_misc: got busy_first=%0d flag_leak=%0d need 1 and 0", busy_first, flag_leak);
    end
  endtask

  task automatic test_stall();
    drive_frame(0, 2, 3, 1'b0, -1, 1'b0, 1'b0);
    checks++;
    if (obs_data.size() != N) begin errors++; $display("FAIL stall_count: got %0d beats, need %0d", obs_data.size(), N); end
    for (int k = 0; k < obs_data.size() && k < N; k++) begin
      checks++;
      if (obs_data[k] !== W'(k + 1) || obs_eol[k] !== ref_eol(k) || obs_sof[k] !== (k == 0)) begin
        errors++; $display("FAIL stall_beat k=%0d: got data=%0d eol=%b sof=%b need data=%0d eol=%b sof=%b",
                           k, obs_data[k], obs_eol[k], obs_sof[k], k + 1, ref_eol(k), k == 0);
      end
      if (k > 0) begin
        checks++;
        if (obs_cyc[k] - obs_cyc[k-1] != ((k == 2) ? 4 : ref_min_gap(k))) begin
          errors++; $display("FAIL stall_gap k=%0d: got %0d need %0d", k, obs_cyc[k] - obs_cyc[k-1], (k == 2) ? 4 : ref_min_gap(k));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      drive_frame(40, -1, 0, 1'b0, -1, 1'b1, 1'b0);
      checks++;
      if (obs_data.size() != N || exp_data.size() != N) begin
        errors++; $display("FAIL rand_count f=%0d: got %0d beats %0d transfers, need %0d", f, obs_data.size(), exp_data.size(), N);
      end
      for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
        checks++;
        if (obs_data[k] !== exp_data[k] || obs_eol[k] !== ref_eol(k) || obs_sof[k] !== (k == 0)) begin
          errors++; $display("FAIL rand_beat f=%0d k=%0d: got data=%0d eol=%b sof=%b need data=%0d eol=%b sof=%b",
                             f, k, obs_data[k], obs_eol[k], obs_sof[k], exp_data[k], ref_eol(k), k == 0);
        end
        if (k > 0) begin
          checks++;
          if (obs_cyc[k] - obs_cyc[k-1] < ref_min_gap(k)) begin
            errors++; $display("FAIL rand_gap f=%0d k=%0d: got %0d need >= %0d", f, k, obs_cyc[k] - obs_cyc[k-1], ref_min_gap(k));
          end
        end
      end
      if (obs_cyc.size() > 0) begin
        checks++;
        if (busy_drop - obs_cyc[obs_cyc.size()-1] != VB || flag_leak != 0) begin
          errors++; $display("FAIL rand_tail f=%0d: got busy drop %0d after last beat, leak %0d, need %0d and 0",
                             f, busy_drop - obs_cyc[obs_cyc.size()-1], flag_leak, VB);
        end
      end
    end
  endtask

  task automatic test_busy_start();
    int sofs;
    drive_frame(0, -1, 0, 1'b1, -1, 1'b0, 1'b0);
    sofs = 0;
    foreach (obs_sof[k]) sofs += int'(obs_sof[k]);
    checks++;
    if (obs_data.size() != N || sofs != 1) begin
      errors++; $display("FAIL busy_start_ignored: got %0d beats %0d sof, need %0d and 1", obs_data.size(), sofs, N);
    end
    if (obs_cyc.size() > 0) begin
      checks++;
      if (busy_drop - obs_cyc[obs_cyc.size()-1] != VB) begin
        errors++; $display("FAIL busy_start_tail: got %0d need %0d", busy_drop - obs_cyc[obs_cyc.size()-1], VB);
      end
    end
    drive_frame(0, -1, 0, 1'b0, -1, 1'b0, 1'b0);
    checks++;
    if (busy_first != 1) begin errors++; $display("FAIL first_idle_start: got busy=%0d after start, need 1", busy_first); end
    checks++;
    if (obs_data.size() != N || (obs_sof.size() > 0 && obs_sof[0] !== 1'b1)) begin
      errors++; $display("FAIL second_frame: got %0d beats, need %0d with sof on first", obs_data.size(), N);
    end
  endtask

  task automatic test_reset_mid();
    drive_frame(0, -1, 0, 1'b0, H + 2, 1'b0, 1'b0);
    rst = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b need 0", m_valid); end
    checks++; if (m_sof !== 1'b0)   begin errors++; $display("FAIL rst_mid_sof: got %b need 0", m_sof); end
    checks++; if (m_eol !== 1'b0)   begin errors++; $display("FAIL rst_mid_eol: got %b need 0", m_eol); end
    checks++; if (m_data !== '0)    begin errors++; $display("FAIL rst_mid_data: got %0d need 0", m_data); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_mid_busy: got %b need 0", busy); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b need 0", s_ready); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    drive_frame(0, -1, 0, 1'b0, -1, 1'b0, 1'b0);
    checks++;
    if (obs_data.size() != N) begin errors++; $display("FAIL rst_restart_count: got %0d need %0d", obs_data.size(), N); end
    for (int k = 0; k < obs_data.size() && k < N; k++) begin
      checks++;
      if (obs_data[k] !== W'(k + 1) || obs_sof[k] !== (k == 0) || obs_eol[k] !== ref_eol(k)) begin
        errors++; $display("FAIL rst_restart_beat k=%0d: got data=%0d sof=%b eol=%b need data=%0d sof=%b eol=%b",
                           k, obs_data[k], obs_sof[k], obs_eol[k], k + 1, k == 0, ref_eol(k));
      end
    end
  endtask

`ifdef RASTER_STREAM_TPG_EN
  task automatic test_tpg();
    drive_frame(0, -1, 0, 1'b0, -1, 1'b0, 1'b1);
    tpg_on = 1'b0;
    checks++;
    if (obs_data.size() != N || ready_seen != 0 || exp_data.size() != 0) begin
      errors++; $display("FAIL tpg_frame: got %0d beats, ready seen %0d, %0d transfers, need %0d, 0, 0",
                         obs_data.size(), ready_seen, exp_data.size(), N);
    end
    for (int k = 0; k < obs_data.size() && k < N; k++) begin
      checks++;
      if (obs_data[k] !== W'((k % H) + (k / H)) || obs_eol[k] !== ref_eol(k) || obs_sof[k] !== (k == 0)) begin
        errors++; $display("FAIL tpg_beat k=%0d: got data=%0d eol=%b sof=%b need data=%0d eol=%b sof=%b",
                           k, obs_data[k], obs_eol[k], obs_sof[k], (k % H) + (k / H), ref_eol(k), k == 0);
      end
      if (k > 0) begin
        checks++;
        if (obs_cyc[k] - obs_cyc[k-1] != ref_min_gap(k)) begin
          errors++; $display("FAIL tpg_gap k=%0d: got %0d need %0d", k, obs_cyc[k] - obs_cyc[k-1], ref_min_gap(k));
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_busy_start();
    test_reset_mid();
`ifdef RASTER_STREAM_TPG_EN
    test_tpg();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
